// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM burst arbiter.
//   - arb_state_e      : arbiter FSM state encoding
//   - DEF_BURST_LEN    : default fixed burst length
//   - DEF_TIMEOUT_CYCLES: default burst_req-to-finish abort limit
//   - slot_w()         : width of an arbitration slot index (2*N_CH slots)
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam int DEF_BURST_LEN      = 128;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Slots 0..N_CH-1 are writers, N_CH..2*N_CH-1 are readers.
  function automatic int slot_w(input int n_ch);
    return (2 * n_ch > 1) ? $clog2(2 * n_ch) : 1;
  endfunction

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// SDRAM controller user-interface burst port (write and read halves).
//   master : arbiter side (drives req/len/addr/write data)
//   slave  : controller side (drives data_req/finish/read data/valid)
interface sdram_burst_arbiter_if #(
  parameter int ADDR_WIDTH     = 24,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int BURST_WIDTH    = 8
);
  logic                      wr_burst_req;
  logic [BURST_WIDTH-1:0]    wr_burst_len;
  logic [ADDR_WIDTH-1:0]     wr_burst_addr;
  logic                      wr_burst_data_req;
  logic [MEM_DATA_WIDTH-1:0] wr_burst_data;
  logic                      wr_burst_finish;

  logic                      rd_burst_req;
  logic [BURST_WIDTH-1:0]    rd_burst_len;
  logic [ADDR_WIDTH-1:0]     rd_burst_addr;
  logic                      rd_burst_data_valid;
  logic [MEM_DATA_WIDTH-1:0] rd_burst_data;
  logic                      rd_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );
endinterface

// File: rtl/sdram_burst_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector
//   ptr_i   : highest-priority slot this round
//   grant_o : one-hot winner (0 when no request)
//   idx_o   : winner index (0 when no request)
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] cand_s;

  // Scan from the farthest offset down so the slot nearest the pointer wins last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand_s  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand_s = {1'b0, ptr_i} + (IW + 1)'(i);
      cand_s = (cand_s >= (IW + 1)'(N)) ? (cand_s - (IW + 1)'(N)) : cand_s;
      if (req_i[cand_s[IW-1:0]]) begin
        grant_o                   = '0;
        grant_o[cand_s[IW-1:0]]   = 1'b1;
        idx_o                     = cand_s[IW-1:0];
      end else begin
        grant_o = grant_o;
        idx_o   = idx_o;
      end
    end
  end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst port between N_CH writers and
// N_CH readers. One burst at a time; grant, address and burst_req are
// registered, data strobes are steered combinationally to the granted channel.
//   i_sys_clk/i_sys_rst        : clock, synchronous active-high reset
//   i_wr_req/i_wr_addr/i_wr_data: writer requests, base addresses, write data
//   o_wr_grant/o_wr_data_req/o_wr_done : writer grant, steered data_req, done pulse
//   i_rd_req/i_rd_addr         : reader requests and base addresses
//   o_rd_grant/o_rd_data_valid/o_rd_data/o_rd_done : reader side outputs
//   o_timeout                  : pulse when a burst is aborted without finish
//   sdram                      : controller burst port (master side)
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int ADDR_WIDTH     = 24,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int BURST_WIDTH    = 8,
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           i_sys_clk,
  input  logic                           i_sys_rst,
  input  logic [N_CH-1:0]                i_wr_req,
  input  logic [N_CH*ADDR_WIDTH-1:0]     i_wr_addr,
  input  logic [N_CH*MEM_DATA_WIDTH-1:0] i_wr_data,
  output logic [N_CH-1:0]                o_wr_grant,
  output logic [N_CH-1:0]                o_wr_data_req,
  output logic [N_CH-1:0]                o_wr_done,
  input  logic [N_CH-1:0]                i_rd_req,
  input  logic [N_CH*ADDR_WIDTH-1:0]     i_rd_addr,
  output logic [N_CH-1:0]                o_rd_grant,
  output logic [N_CH-1:0]                o_rd_data_valid,
  output logic [MEM_DATA_WIDTH-1:0]      o_rd_data,
  output logic [N_CH-1:0]                o_rd_done,
  output logic                           o_timeout,
  sdram_burst_arbiter_if.master          sdram
);

  localparam int NS = 2 * N_CH;
  localparam int SW = slot_w(N_CH);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_GAP   = ST_GAP;

  logic [1:0]            state_q, state_d;
  logic [SW-1:0]         ptr_q, ptr_d;
  logic [N_CH-1:0]       wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
  logic [N_CH-1:0]       wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic                  wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [NS-1:0]         arb_grant_s;
  logic [SW-1:0]         arb_idx_s;
  logic [SW:0]           ptr_nxt_s;
  logic [ADDR_WIDTH-1:0] win_addr_s;
  logic                  any_req_s;
  logic                  fin_s;

  rr_arbiter #(.N(NS)) u_rr_arbiter (
    .req_i   ({i_rd_req, i_wr_req}),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s)
  );

  assign any_req_s = |{i_rd_req, i_wr_req};
  assign ptr_nxt_s = {1'b0, arb_idx_s} + (SW + 1)'(1);
  // Only the finish of the port actually in use counts.
  assign fin_s = (state_q == S_WRITE) ? sdram.wr_burst_finish : sdram.rd_burst_finish;

  // Pick the winner's base address from its one-hot grant.
  always_comb begin
    win_addr_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (arb_grant_s[k]) begin
        win_addr_s = i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end else if (arb_grant_s[N_CH+k]) begin
        win_addr_s = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  // Arbitration FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_grant_d = wr_grant_q;
    rd_grant_d = rd_grant_q;
    wr_req_d   = wr_req_q;
    rd_req_d   = rd_req_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wr_done_d  = '0;
    rd_done_d  = '0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          addr_d     = win_addr_s;
          cnt_d      = '0;
          ptr_d      = (ptr_nxt_s == (SW + 1)'(NS)) ? '0 : ptr_nxt_s[SW-1:0];
          wr_grant_d = arb_grant_s[N_CH-1:0];
          rd_grant_d = arb_grant_s[NS-1:N_CH];
          if (arb_idx_s < SW'(N_CH)) begin
            wr_req_d = 1'b1;
            state_d  = S_WRITE;
          end else begin
            rd_req_d = 1'b1;
            state_d  = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE, S_READ: begin
        // Finish takes precedence over a timeout in the same cycle.
        if (fin_s || (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
          wr_done_d  = fin_s ? wr_grant_q : '0;
          rd_done_d  = fin_s ? rd_grant_q : '0;
          timeout_d  = ~fin_s;
          wr_req_d   = 1'b0;
          rd_req_d   = 1'b0;
          wr_grant_d = '0;
          rd_grant_d = '0;
          state_d    = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        wr_req_d   = 1'b0;
        rd_req_d   = 1'b0;
        wr_grant_d = '0;
        rd_grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      wr_grant_q <= '0;
      rd_grant_q <= '0;
      wr_done_q  <= '0;
      rd_done_q  <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      timeout_q  <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      timeout_q  <= timeout_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Write data of the granted channel, zero when nothing is granted.
  always_comb begin
    sdram.wr_burst_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (wr_grant_q[k]) begin
        sdram.wr_burst_data = i_wr_data[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
      end else begin
        sdram.wr_burst_data = sdram.wr_burst_data;
      end
    end
  end

  assign sdram.wr_burst_req  = wr_req_q;
  assign sdram.rd_burst_req  = rd_req_q;
  assign sdram.wr_burst_addr = addr_q;
  assign sdram.rd_burst_addr = addr_q;
  assign sdram.wr_burst_len  = BURST_WIDTH'(BURST_LEN);
  assign sdram.rd_burst_len  = BURST_WIDTH'(BURST_LEN);

  // Grants are zero outside WRITE/READ, so stray strobes are masked here.
  assign o_wr_data_req   = {N_CH{sdram.wr_burst_data_req}} & wr_grant_q;
  assign o_rd_data_valid = {N_CH{sdram.rd_burst_data_valid}} & rd_grant_q;
  assign o_rd_data       = sdram.rd_burst_data;
  assign o_wr_grant      = wr_grant_q;
  assign o_rd_grant      = rd_grant_q;
  assign o_wr_done       = wr_done_q;
  assign o_rd_done       = rd_done_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
module tb_sdram_burst_arbiter;
  import sdram_arb_pkg::*;

  localparam int N_CH = 2;
  localparam int AW   = 24;
  localparam int DW   = 16;
  localparam int BW   = 8;

  typedef struct {
    int          slot;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N_CH-1:0]      wr_req, rd_req, t_wr_req, t_rd_req;
  logic [N_CH*AW-1:0]   wr_addr, rd_addr;
  logic [N_CH*DW-1:0]   wr_data;
  logic [N_CH-1:0]      wr_grant, wr_data_req, wr_done, rd_grant, rd_data_valid, rd_done;
  logic [DW-1:0]        rd_data;
  logic                 timeout;
  logic [N_CH-1:0]      t_wr_grant, t_wr_data_req, t_wr_done, t_rd_grant, t_rd_data_valid, t_rd_done;
  logic [DW-1:0]        t_rd_data;
  logic                 t_timeout;

  sdram_burst_arbiter_if #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();
  sdram_burst_arbiter_if #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus2 ();

  sdram_burst_arbiter #(.N_CH(N_CH), .ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .BURST_WIDTH(BW),
                        .BURST_LEN(128), .TIMEOUT_CYCLES(4096)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_grant(wr_grant), .o_wr_data_req(wr_data_req), .o_wr_done(wr_done),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_grant(rd_grant), .o_rd_data_valid(rd_data_valid), .o_rd_data(rd_data), .o_rd_done(rd_done),
    .o_timeout(timeout), .sdram(bus)
  );

  sdram_burst_arbiter #(.N_CH(N_CH), .ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .BURST_WIDTH(BW),
                        .BURST_LEN(128), .TIMEOUT_CYCLES(64)) dut_to (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_wr_req(t_wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_grant(t_wr_grant), .o_wr_data_req(t_wr_data_req), .o_wr_done(t_wr_done),
    .i_rd_req(t_rd_req), .i_rd_addr(rd_addr),
    .o_rd_grant(t_rd_grant), .o_rd_data_valid(t_rd_data_valid), .o_rd_data(t_rd_data), .o_rd_done(t_rd_done),
    .o_timeout(t_timeout), .sdram(bus2)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a burst to start, then compare against the scoreboard head.
  task automatic wait_start(output int slot);
    int k;
    exp_t e;
    logic [AW-1:0] a;
    k = 0;
    while (!(bus.wr_burst_req || bus.rd_burst_req) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("start_latency", k, 1);
    a = '0;
    slot = 9;
    if (bus.wr_burst_req) begin
      slot = (wr_grant == 2'b01) ? 0 : (wr_grant == 2'b10) ? 1 : 9;
      a = bus.wr_burst_addr;
      check_val("wr_len", bus.wr_burst_len, 128);
    end else if (bus.rd_burst_req) begin
      slot = (rd_grant == 2'b01) ? 2 : (rd_grant == 2'b10) ? 3 : 9;
      a = bus.rd_burst_addr;
      check_val("rd_len", bus.rd_burst_len, 128);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("grant_slot", slot, e.slot);
      check_val("burst_addr", a, e.addr);
    end else begin
      check_val("scoreboard_underflow", sb_q.size(), 1);
    end
  endtask

  // Serve one burst: hold checks, strobe steering, finish, done pulse and GAP.
  task automatic do_burst(input int fin_after, input int beats, input bit drop);
    int slot, hold_err, v0, v1, derr, werr;
    logic [N_CH-1:0] oh, g_w, g_r;
    wait_start(slot);
    if (drop) begin
      wr_req = '0;
      rd_req = '0;
    end
    oh  = (slot == 1 || slot == 3) ? 2'b10 : 2'b01;
    g_w = (slot < 2) ? oh : 2'b00;
    g_r = (slot < 2) ? 2'b00 : oh;
    hold_err = 0; v0 = 0; v1 = 0; derr = 0; werr = 0;
    for (int c = 0; c < fin_after; c++) begin
      if (wr_grant !== g_w || rd_grant !== g_r || (bus.wr_burst_req | bus.rd_burst_req) !== 1'b1)
        hold_err++;
      bus.rd_burst_data_valid = (slot >= 2 && c < beats) ? 1'b1 : 1'b0;
      bus.wr_burst_data_req   = (slot < 2 && c < beats) ? 1'b1 : 1'b0;
      bus.rd_burst_data       = DW'($urandom);
      #1;
      v0 += int'(rd_data_valid[0]);
      v1 += int'(rd_data_valid[1]);
      if (rd_data !== bus.rd_burst_data) derr++;
      if (wr_data_req !== (bus.wr_burst_data_req ? g_w : 2'b00)) werr++;
      if (slot < 2 && bus.wr_burst_data !== wr_data[slot*DW +: DW]) werr++;
      if (c == fin_after - 1) begin
        if (slot < 2) bus.wr_burst_finish = 1'b1;
        else bus.rd_burst_finish = 1'b1;
      end
      @(negedge clk);
    end
    bus.wr_burst_finish = 1'b0;
    bus.rd_burst_finish = 1'b0;
    bus.rd_burst_data_valid = 1'b0;
    bus.wr_burst_data_req = 1'b0;
    check_val("grant_hold", hold_err, 0);
    check_val("rd_valid0_beats", v0, (slot == 2) ? beats : 0);
    check_val("rd_valid1_beats", v1, (slot == 3) ? beats : 0);
    check_val("rd_data_pass", derr, 0);
    check_val("wr_steer", werr, 0);
    check_val("wr_done", wr_done, g_w);
    check_val("rd_done", rd_done, g_r);
    check_val("req_drop", bus.wr_burst_req | bus.rd_burst_req, 0);
    check_val("grant_drop", {wr_grant, rd_grant}, 0);
    check_val("no_timeout", timeout, 0);
    @(negedge clk);
    check_val("gap_done_clear", {wr_done, rd_done}, 0);
    check_val("gap_req_low", bus.wr_burst_req | bus.rd_burst_req, 0);
  endtask

  initial begin
    int k, n;
    rst = 1'b1;
    wr_req = '0; rd_req = '0; t_wr_req = '0; t_rd_req = '0;
    wr_addr = {24'h000200, 24'h000100};
    rd_addr = {24'h900000, 24'h800000};
    wr_data = {16'hBEEF, 16'h1234};
    bus.wr_burst_data_req = 1'b0; bus.wr_burst_finish = 1'b0;
    bus.rd_burst_data_valid = 1'b0; bus.rd_burst_data = '0; bus.rd_burst_finish = 1'b0;
    bus2.wr_burst_data_req = 1'b0; bus2.wr_burst_finish = 1'b0;
    bus2.rd_burst_data_valid = 1'b0; bus2.rd_burst_data = '0; bus2.rd_burst_finish = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check_val("rst_req", {bus.wr_burst_req, bus.rd_burst_req, bus2.wr_burst_req}, 0);
    check_val("rst_grant", {wr_grant, rd_grant}, 0);
    check_val("rst_done", {wr_done, rd_done, timeout}, 0);
    check_val("rst_addr", {bus.wr_burst_addr, bus.rd_burst_addr}, 0);
    rst = 1'b0;

    // All four requests held: wr0, wr1, rd0, rd1, wr0.
    wr_req = 2'b11; rd_req = 2'b11;
    sb_q.push_back('{0, 24'h000100});
    sb_q.push_back('{1, 24'h000200});
    sb_q.push_back('{2, 24'h800000});
    sb_q.push_back('{3, 24'h900000});
    sb_q.push_back('{0, 24'h000100});
    for (int i = 0; i < 5; i++) do_burst(20, 3, i == 4);
    repeat (3) @(negedge clk);
    check_val("idle_after_rr", bus.wr_burst_req | bus.rd_burst_req, 0);

    // Read burst on rd0 with 128 valid beats.
    rd_req = 2'b01;
    sb_q.push_back('{2, 24'h800000});
    do_burst(130, 128, 1'b1);

    // Single write on wr0, finish 140 cycles in.
    wr_req = 2'b01;
    sb_q.push_back('{0, 24'h000100});
    do_burst(140, 4, 1'b1);

    // Stray strobes in IDLE are ignored.
    bus.wr_burst_finish = 1'b1; bus.rd_burst_finish = 1'b1;
    bus.wr_burst_data_req = 1'b1; bus.rd_burst_data_valid = 1'b1;
    #1;
    check_val("stray_steer", {wr_data_req, rd_data_valid}, 0);
    @(negedge clk);
    bus.wr_burst_finish = 1'b0; bus.rd_burst_finish = 1'b0;
    bus.wr_burst_data_req = 1'b0; bus.rd_burst_data_valid = 1'b0;
    check_val("stray_done", {wr_done, rd_done, timeout}, 0);
    check_val("stray_req", bus.wr_burst_req | bus.rd_burst_req, 0);

    // Timeout on the short-timeout instance.
    t_wr_req = 2'b01;
    k = 0;
    while (!bus2.wr_burst_req && k < 10) begin @(negedge clk); k++; end
    check_val("to_start", k, 1);
    n = 0;
    while (bus2.wr_burst_req && n < 200) begin @(negedge clk); n++; end
    check_val("to_req_cycles", n, 64);
    check_val("to_pulse", t_timeout, 1);
    check_val("to_no_done", t_wr_done, 0);
    check_val("to_grant_drop", t_wr_grant, 0);
    @(negedge clk);
    check_val("to_pulse_width", t_timeout, 0);
    check_val("to_gap", bus2.wr_burst_req, 0);
    @(negedge clk);
    check_val("to_idle_restart", bus2.wr_burst_req, 1);
    t_wr_req = '0;
    // Finish coinciding with the timeout cycle: done wins.
    repeat (63) @(negedge clk);
    bus2.wr_burst_finish = 1'b1;
    @(negedge clk);
    bus2.wr_burst_finish = 1'b0;
    check_val("fin_vs_to_done", t_wr_done, 2'b01);
    check_val("fin_vs_to_timeout", t_timeout, 0);

    // Reset in the middle of a write burst (pointer is at wr1).
    wr_req = 2'b11; rd_req = 2'b11;
    sb_q.push_back('{1, 24'h000200});
    wait_start(k);
    repeat (5) @(negedge clk);
    bus.wr_burst_data_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_req", bus.wr_burst_req | bus.rd_burst_req, 0);
    check_val("mid_rst_grant", {wr_grant, rd_grant}, 0);
    check_val("mid_rst_done", {wr_done, rd_done, timeout}, 0);
    check_val("mid_rst_addr", bus.wr_burst_addr, 0);
    check_val("mid_rst_steer", wr_data_req, 0);
    bus.wr_burst_data_req = 1'b0;
    sb_q.push_back('{0, 24'h000100});
    rst = 1'b0;
    do_burst(10, 2, 1'b1);
    check_val("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
